// File: rtl/alu_ctrl_issue.sv
// ALU control issue: decodes ALUOp/funct into the 4-bit ALU op code,
// registers it for EX and sequences the multi-cycle DIVU window.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             squash the EX-bound op
//   in_valid/in_ready decode handshake (in_ready = !div_busy)
//   alu_op, funct     main-control class and R-type funct
//   signal_out        registered ALU operation code
//   out_valid         signal_out carries a live op
//   illegal           unmapped R-type funct seen
//   div_busy/div_done DIVU window active / final window cycle
module alu_ctrl_issue #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] signal_out,
  output logic       out_valid,
  output logic       illegal,
  output logic       div_busy,
  output logic       div_done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DIV  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_op;
  logic             dec_ill;
  logic             dec_div;
  logic             accept;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    unique case (1'b1)
      alu_op == 2'b00: dec_op = OP_ADD;
      alu_op == 2'b01: dec_op = OP_SUB;
      alu_op == 2'b11: dec_op = OP_BNE;
      alu_op == 2'b10: begin
        case (funct)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b000000: dec_op = OP_SLL;
          6'b011011: dec_op = OP_DIVU;
          default: begin
            dec_op  = OP_ADD;
            dec_ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign dec_div  = (dec_op == OP_DIVU);
  assign div_busy = (state == DIV);
  assign div_done = div_busy && (cnt == '0);
  assign in_ready = !div_busy;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= IDLE;
      cnt        <= '0;
      signal_out <= OP_ADD;
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            signal_out <= dec_op;
            out_valid  <= 1'b1;
            illegal    <= dec_ill;
            if (dec_div) begin
              state <= DIV;
              cnt   <= CNT_LOAD;
            end
          end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        DIV: begin
          // op stays on the bus until the window closes
          illegal <= 1'b0;
          if (cnt == '0) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else begin
            cnt       <= cnt - 1'b1;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: directed plan sequences
// followed by random traffic against a cycle-level reference model.
module tb_alu_ctrl_issue;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       in_ready;
  logic [3:0] signal_out;
  logic       out_valid;
  logic       illegal;
  logic       div_busy;
  logic       div_done;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.DIV_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .signal_out(signal_out), .out_valid(out_valid),
    .illegal(illegal), .div_busy(div_busy),
    .div_done(div_done)
  );

  // record: {sig[3:0], out_valid, illegal, busy, done, ready}
  logic [8:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // reference model: rem = busy cycles still to show from now on
  int         m_rem = 0;
  logic [3:0] m_sig = 4'b0010;
  bit         m_ov  = 0;
  bit         m_ill = 0;

  function automatic void ref_decode(input logic [1:0] op,
                                     input logic [5:0] fn,
                                     output logic [3:0] s,
                                     output bit il);
    il = 0;
    if (op == 2'b00) s = 4'd2;
    else if (op == 2'b01) s = 4'd6;
    else if (op == 2'b11) s = 4'd5;
    else begin
      case (fn)
        6'b100000: s = 4'd2;
        6'b100010: s = 4'd6;
        6'b100100: s = 4'd0;
        6'b100101: s = 4'd1;
        6'b101010: s = 4'd7;
        6'b000000: s = 4'd3;
        6'b011011: s = 4'd4;
        default: begin s = 4'd2; il = 1; end
      endcase
    end
  endfunction

  task automatic step(input bit r, input bit f, input bit v,
                      input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] s;
    bit il;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; alu_op = op; funct = fn;
    if (r || f) begin
      m_sig = 4'd2; m_ov = 0; m_ill = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      m_ov  = (m_rem > 0);
      m_ill = 0;
    end else if (v) begin
      ref_decode(op, fn, s, il);
      m_sig = s; m_ov = 1; m_ill = il;
      if (s == 4'd4) m_rem = DC;
    end else begin
      m_ov = 0; m_ill = 0;
    end
    exp_q.push_back({m_sig, m_ov, m_ill, m_rem > 0,
                     m_rem == 1, m_rem == 0});
  endtask

  // monitor: compares what the DUT shows after each edge
  initial begin
    logic [8:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {signal_out, out_valid, illegal, div_busy,
             div_done, in_ready};
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL cycle_out t=%0t got sig=%b ov=%b ill=%b busy=%b done=%b rdy=%b want sig=%b ov=%b ill=%b busy=%b done=%b rdy=%b",
                      $time, a[8:5], a[4], a[3], a[2], a[1], a[0],
                      e[8:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  logic [5:0] legal_fn [7] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010, 6'b000000,
                               6'b011011};

  initial begin
    logic [5:0] fn;
    int k;
    step(1, 0, 0, 2'b00, 6'd0);
    step(1, 0, 1, 2'b01, 6'd0);
    // plan 1: R-type stream
    for (int i = 0; i < 6; i++) step(0, 0, 1, 2'b10, legal_fn[i]);
    // plan 2: classes and an illegal funct
    step(0, 0, 1, 2'b00, 6'd0);
    step(0, 0, 1, 2'b01, 6'd0);
    step(0, 0, 1, 2'b11, 6'd0);
    step(0, 0, 1, 2'b10, 6'b111111);
    step(0, 0, 0, 2'b00, 6'd0);
    // plan 3: DIVU, then ADD held on in_valid
    step(0, 0, 1, 2'b10, 6'b011011);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 2'b00, 6'd0);
    step(0, 0, 0, 2'b00, 6'd0);
    // plan 4: flush mid-DIVU
    step(0, 0, 1, 2'b10, 6'b011011);
    step(0, 0, 0, 2'b00, 6'd0);
    step(0, 1, 0, 2'b00, 6'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 6'd0);
    // flush in final DIV cycle
    step(0, 0, 1, 2'b10, 6'b011011);
    for (int i = 0; i < DC - 1; i++) step(0, 0, 0, 2'b00, 6'd0);
    step(0, 1, 0, 2'b00, 6'd0);
    step(0, 0, 0, 2'b00, 6'd0);
    // plan 5: flush collides with accept
    step(0, 1, 1, 2'b01, 6'd0);
    step(0, 0, 0, 2'b00, 6'd0);
    // plan 6: reset mid-DIVU, then immediate accept
    step(0, 0, 1, 2'b10, 6'b011011);
    step(0, 0, 0, 2'b00, 6'd0);
    step(0, 0, 0, 2'b00, 6'd0);
    step(1, 0, 1, 2'b11, 6'd0);
    step(0, 0, 1, 2'b11, 6'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 6'd0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7) fn = legal_fn[k];
      else if (k == 7) fn = 6'b011011;
      else fn = 6'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) != 0, 2'($urandom), fn);
    end
    step(0, 0, 0, 2'b00, 6'd0);
    @(posedge clk);
    #3;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain left=%0d want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
